alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
Registered operand stage directly upstream of the ALU operand-B select muxes. Accepts decoded instruction operands, extends the 16-bit immediate, and presents per-bit mux inputs: in0 = register operand, in1 = extended immediate, s = alu_src. The muxes therefore see stable, glitch-free inputs for a full cycle.
A 2-entry skid buffer with valid/ready handshake on both sides decouples the decode logic from ALU stalls.

Parameters:
WIDTH, 32, datapath width of the operands.
IMM_WIDTH, 16, width of the raw immediate field; must be less than WIDTH.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  upstream presents an operand set.
in_ready  output  1  stage can accept an operand set this cycle.
in_rs  input  WIDTH  register operand A.
in_rt  input  WIDTH  register operand B.
in_imm  input  IMM_WIDTH  raw immediate field.
in_ext_mode  input  2  immediate extension: 00 zero, 01 sign, 10 upper, 11 reserved.
in_alu_src  input  1  0 selects rt, 1 selects immediate.
out_valid  output  1  operand set held at outputs is valid.
out_ready  input  1  ALU consumes the current operand set.
op_a  output  WIDTH  registered rs.
mux_in0  output  WIDTH  registered rt; drives in0 of every per-bit mux.
mux_in1  output  WIDTH  registered extended immediate; drives in1 of every per-bit mux.
mux_sel  output  1  registered alu_src; drives s of every per-bit mux.

Behaviour:
- Reset, which is synchronous and takes priority over everything else:
  - out_valid=0, in_ready=1, skid_full=0.
  - op_a, mux_in0, mux_in1 and mux_sel all 0.
  - Reset asserted mid-transfer drops both entries; no partial data survives.
- Transfers:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Latency: an accepted set appears at the outputs on the next cycle (1 cycle) when the output register is empty or being consumed in the same cycle.
- Storage: an output register plus one skid register.
  - in_ready = !skid_full. It is registered and does not depend combinationally on out_ready.
- States, encoded by {out_valid, skid_full}:
  - EMPTY (0,0): accept -> BUSY.
  - BUSY (1,0):
    - Accept without consume -> FULL; the new set goes into the skid register.
    - Accept with consume -> BUSY; the output register is reloaded with the new set.
    - Consume without accept -> EMPTY.
    - Neither -> BUSY, outputs held.
  - FULL (1,1):
    - Consume -> BUSY; the skid register moves to the output register.
    - No accept is possible, since in_ready=0.
- Outputs hold their value while out_valid && !out_ready. In EMPTY, data outputs keep their last value.
- Immediate extension, computed before registering:
  - zero: {0..., imm}.
  - sign: {imm[IMM_WIDTH-1] replicated, imm}.
  - upper: imm << (WIDTH-IMM_WIDTH), low bits 0.
  - reserved (11): treated as zero and no error is flagged.
- Ordering: strict FIFO; sets are never dropped or duplicated.
- Timing: no combinational path from any in_* port to any out/mux port.

Decomposition:
- Shared package alu_pkg:
  - Extension-mode constants EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_UPPER=2'b10, EXT_RSVD=2'b11.
  - Default WIDTH/IMM_WIDTH constants.
- Sub-module imm_extend: purely combinational; inputs imm and ext_mode, output WIDTH-bit extended value. Instantiated once on the input side.

Test Plan:
- Reset: assert reset for 2 cycles while in_valid=1 -> out_valid=0, in_ready=1, all data outputs 0; no set is accepted during reset.
- Basic pass-through with sign extension: rs=0x00000005, rt=0x0000000A, imm=0xFFFC, mode=01, alu_src=1, out_ready=1 -> one cycle later out_valid=1, op_a=0x00000005, mux_in0=0x0000000A, mux_in1=0xFFFFFFFC, mux_sel=1.
- Extension modes on imm=0x8001:
  - mode 00 -> 0x00008001.
  - mode 10 -> 0x80010000.
  - mode 11 -> 0x00008001.
- Backpressure: out_ready=0, send sets S1 and S2 back to back:
  - After S2, in_ready=0 and the outputs hold S1.
  - Raise out_ready -> S1 then S2 are delivered in order; in_ready returns to 1 one cycle after the first consume.
- Simultaneous accept and consume in BUSY: stream 8 sets with in_valid=out_ready=1 every cycle -> one set out per cycle, skid never fills, order preserved.
- Reset in FULL: hold S1 and S2 buffered, then pulse reset -> out_valid=0, in_ready=1; S1 and S2 never appear at the outputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand stage: extension-mode encodings,
// default datapath widths and the skid-buffer state encoding.
package alu_pkg;

    // Immediate extension modes as decoded from the instruction.
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    localparam logic [1:0] EXT_RSVD  = 2'b11;

    localparam int unsigned DEFAULT_WIDTH     = 32;
    localparam int unsigned DEFAULT_IMM_WIDTH = 16;

    // Encoded as {out_valid, skid_full} so both flags decode straight from the state.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b10,
        StFull  = 2'b11
    } stage_state_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Handshake and operand bus between decode, the operand stage and the ALU mux inputs.
interface alu_operand_stage_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned IMM_WIDTH = DEFAULT_IMM_WIDTH
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_rs;
    logic [WIDTH-1:0]     in_rt;
    logic [IMM_WIDTH-1:0] in_imm;
    logic [1:0]           in_ext_mode;
    logic                 in_alu_src;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     mux_in0;
    logic [WIDTH-1:0]     mux_in1;
    logic                 mux_sel;

    // Environment side: drives decoded operands and the ALU consume strobe.
    modport master (
        output in_valid, in_rs, in_rt, in_imm, in_ext_mode, in_alu_src, out_ready,
        input  in_ready, out_valid, op_a, mux_in0, mux_in1, mux_sel
    );

    // Operand stage side.
    modport slave (
        input  in_valid, in_rs, in_rt, in_imm, in_ext_mode, in_alu_src, out_ready,
        output in_ready, out_valid, op_a, mux_in0, mux_in1, mux_sel
    );

endinterface

// File: rtl/imm_extend.sv
// Combinational immediate extender: zero, sign or upper placement of the raw field.
module imm_extend
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned IMM_WIDTH = DEFAULT_IMM_WIDTH
) (
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic [1:0]           ext_mode,
    output logic [WIDTH-1:0]     ext
);

    localparam int unsigned PAD = WIDTH - IMM_WIDTH;

    // Select the extension; the reserved encoding quietly behaves as zero-extend.
    always_comb begin
        ext = {{PAD{1'b0}}, imm};
        unique case (ext_mode)
            EXT_ZERO:  ext = {{PAD{1'b0}}, imm};
            EXT_SIGN:  ext = {{PAD{imm[IMM_WIDTH-1]}}, imm};
            EXT_UPPER: ext = {imm, {PAD{1'b0}}};
            EXT_RSVD:  ext = {{PAD{1'b0}}, imm};
            default:   ext = {{PAD{1'b0}}, imm};
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage feeding the ALU operand-B muxes, with a 2-entry skid
// buffer so decode can keep streaming while the ALU absorbs a one-cycle stall.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned IMM_WIDTH = DEFAULT_IMM_WIDTH
) (
    input logic               clk,
    input logic               reset,
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0] rs;
        logic [WIDTH-1:0] rt;
        logic [WIDTH-1:0] imm;
        logic             src;
    } operand_t;

    stage_state_e     state;
    operand_t         out_reg;
    operand_t         skid_reg;
    operand_t         new_set;
    logic [WIDTH-1:0] imm_ext;
    logic             accept;
    logic             consume;

    imm_extend #(
        .WIDTH     (WIDTH),
        .IMM_WIDTH (IMM_WIDTH)
    ) u_imm_extend (
        .imm      (bus.in_imm),
        .ext_mode (bus.in_ext_mode),
        .ext      (imm_ext)
    );

    // Both flags come straight from the state register, so neither depends on out_ready.
    assign bus.out_valid = (state != StEmpty);
    assign bus.in_ready  = (state != StFull);

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    assign new_set = '{rs: bus.in_rs, rt: bus.in_rt, imm: imm_ext, src: bus.in_alu_src};

    // Skid-buffer FSM; output register loads from the input or the skid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StEmpty;
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            unique case (state)
                StEmpty: begin
                    if (accept) begin
                        out_reg <= new_set;
                        state   <= StBusy;
                    end
                end
                StBusy: begin
                    if (accept && consume) begin
                        out_reg <= new_set;
                    end else if (accept) begin
                        skid_reg <= new_set;
                        state    <= StFull;
                    end else if (consume) begin
                        state <= StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a consume can happen.
                    if (consume) begin
                        out_reg <= skid_reg;
                        state   <= StBusy;
                    end
                end
                default: state <= StEmpty;
            endcase
        end
    end

    assign bus.op_a    = out_reg.rs;
    assign bus.mux_in0 = out_reg.rt;
    assign bus.mux_in1 = out_reg.imm;
    assign bus.mux_sel = out_reg.src;

endmodule
